// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: sequences D-cache loads/stores, stalls the pipe until dhit, freezes on HALT.
// Optional ACCESS watchdog enabled by defining MEM_WATCHDOG_EN.
module mem_access_ctrl #(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             valid_EX_MEM,
  input  logic             dREN_EX_MEM,
  input  logic             dWEN_EX_MEM,
  input  logic [31:0]      result_EX_MEM,
  input  logic [31:0]      dmemstore_EX_MEM,
  input  logic             halt_EX_MEM,
  input  logic             dhit,
  input  logic [31:0]      dmemload,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic [31:0]      dmemaddr,
  output logic [31:0]      dmemstore,
  output logic [31:0]      load_data_MEM,
  output logic             enable_EX_MEM,
  output logic             enable_MEM_WB,
  output logic             flush_MEM_WB,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE, ST_HALTED} state_t;

  state_t           r_state, w_next;
  logic             r_is_rd, r_is_wr;
  logic [31:0]      r_addr, r_wdata, r_load;
  logic [CNT_W-1:0] r_stall;
  logic             w_memop, w_latch, w_wd_expire;

  assign w_memop = valid_EX_MEM & (dREN_EX_MEM | dWEN_EX_MEM);

`ifdef MEM_WATCHDOG_EN
  localparam int WD_W = (MAX_WAIT < 256) ? 8 : 16;
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_timeout;

  // Counter holds the number of hit-less ACCESS cycles already spent.
  assign w_wd_expire = (r_state == ST_ACCESS) && !dhit &&
                       (r_wd_cnt == WD_W'(MAX_WAIT - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_latch)
        r_wd_cnt <= '0;
      else if (r_state == ST_ACCESS && !dhit)
        r_wd_cnt <= r_wd_cnt + 1'b1;
      if (w_wd_expire)
        r_timeout <= 1'b1;
    end
  end

  assign mem_timeout = r_timeout;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (MAX_WAIT < 0);
  assign w_wd_expire  = 1'b0;
  assign mem_timeout  = 1'b0;
`endif

  always_comb begin
    w_next        = r_state;
    w_latch       = 1'b0;
    enable_EX_MEM = 1'b1;
    enable_MEM_WB = 1'b1;
    flush_MEM_WB  = 1'b0;
    dmemREN       = 1'b0;
    dmemWEN       = 1'b0;
    halted        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_memop) begin
          enable_EX_MEM = 1'b0;
          flush_MEM_WB  = 1'b1;
          w_latch       = 1'b1;
          w_next        = ST_ACCESS;
        end else if (valid_EX_MEM && halt_EX_MEM) begin
          w_next = ST_HALTED;
        end
      end
      ST_ACCESS: begin
        dmemREN       = r_is_rd;
        dmemWEN       = r_is_wr;
        enable_EX_MEM = 1'b0;
        flush_MEM_WB  = 1'b1;
        if (dhit)
          w_next = ST_DONE;
        else if (w_wd_expire)
          w_next = ST_HALTED;
      end
      ST_DONE:   w_next = ST_IDLE;
      ST_HALTED: begin
        enable_EX_MEM = 1'b0;
        enable_MEM_WB = 1'b0;
        halted        = 1'b1;
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_is_rd <= 1'b0;
      r_is_wr <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_load  <= '0;
      r_stall <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_addr  <= result_EX_MEM;
        r_wdata <= dmemstore_EX_MEM;
        // A request flagged as both read and write is treated as a write.
        r_is_wr <= dWEN_EX_MEM;
        r_is_rd <= dREN_EX_MEM & ~dWEN_EX_MEM;
      end
      if (r_state == ST_ACCESS && dhit && r_is_rd)
        r_load <= dmemload;
      if (!enable_EX_MEM && r_state != ST_HALTED && r_stall != {CNT_W{1'b1}})
        r_stall <= r_stall + 1'b1;
    end
  end

  assign dmemaddr      = r_addr;
  assign dmemstore     = r_wdata;
  assign load_data_MEM = r_load;
  assign stall_count   = r_stall;

endmodule
